// File: rtl/vram_arb_pkg.sv
// Shared types for the VRAM port arbiter: requester ownership, response kinds
// and the tag that travels down the read-latency pipeline.
package vram_arb_pkg;

    localparam int DEF_VRAM_WORDS = 600;
    localparam int DEF_CTRL_ADDR  = 600;

    typedef enum logic {
        OWN_VID = 1'b0,
        OWN_CPU = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        K_BRAM = 2'd0,
        K_CTRL = 2'd1,
        K_ZERO = 2'd2
    } kind_e;

    typedef struct packed {
        logic        valid;
        owner_e      owner;
        kind_e       kind;
        logic        err;
        logic [31:0] ctrl_snapshot;
    } rsp_tag_t;

    localparam int TAG_W = $bits(rsp_tag_t);

    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) merged[8*b +: 8] = new_word[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/vram_rsp_pipe.sv
// Read-latency tag pipeline; steers the returning word to the requester that
// owned the grant and selects BRAM data, the captured control value or zero.
module vram_rsp_pipe
    import vram_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [TAG_W-1:0] tag_in,
    input  logic [31:0]      bram_rdata,
    output logic             vid_rsp_valid,
    output logic [31:0]      vid_rsp_data,
    output logic             cpu_rsp_valid,
    output logic [31:0]      cpu_rsp_data,
    output logic             cpu_rsp_err
);

    rsp_tag_t    tag_p [RD_LAT];
    rsp_tag_t    tag_out;
    logic [31:0] rsp_data;

    // Stage boundary: one tag register per cycle of BRAM read latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) tag_p[i].valid <= 1'b0;
        end else begin
            tag_p[0] <= rsp_tag_t'(tag_in);
            for (int i = 1; i < RD_LAT; i++) tag_p[i] <= tag_p[i-1];
        end
    end

    assign tag_out = tag_p[RD_LAT-1];

    always_comb begin
        rsp_data = 32'h0;
        case (tag_out.kind)
            K_BRAM:  rsp_data = bram_rdata;
            K_CTRL:  rsp_data = tag_out.ctrl_snapshot;
            default: rsp_data = 32'h0;
        endcase
    end

    assign vid_rsp_valid = tag_out.valid && (tag_out.owner == OWN_VID);
    assign cpu_rsp_valid = tag_out.valid && (tag_out.owner == OWN_CPU);
    assign cpu_rsp_err   = cpu_rsp_valid && tag_out.err;
    assign vid_rsp_data  = rsp_data;
    assign cpu_rsp_data  = rsp_data;

endmodule

// File: rtl/vram_port_arbiter.sv
// Shares the single text-VRAM BRAM port between video fetch and the CPU,
// with a streak limit on video so CPU accesses cannot starve; owns ctrl_reg.
module vram_port_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W         = 10,
    parameter int VRAM_WORDS     = DEF_VRAM_WORDS,
    parameter int CTRL_ADDR      = DEF_CTRL_ADDR,
    parameter int RD_LAT         = 1,
    parameter int MAX_VID_STREAK = 4
) (
    input  logic              axi_aclk,
    input  logic              axi_aresetn,
    input  logic              vid_req_valid,
    input  logic [ADDR_W-1:0] vid_req_addr,
    output logic              vid_req_ready,
    output logic              vid_rsp_valid,
    output logic [31:0]       vid_rsp_data,
    input  logic              cpu_req_valid,
    input  logic              cpu_req_we,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic [31:0]       cpu_req_wdata,
    input  logic [3:0]        cpu_req_strb,
    output logic              cpu_req_ready,
    output logic              cpu_rsp_valid,
    output logic [31:0]       cpu_rsp_data,
    output logic              cpu_rsp_err,
    output logic              bram_en,
    output logic [3:0]        bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [31:0]       bram_wdata,
    input  logic [31:0]       bram_rdata,
    output logic [31:0]       ctrl_reg
);

    localparam int                STREAK_W   = $clog2(MAX_VID_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_VID_STREAK);
    localparam logic [ADDR_W:0]   VRAM_END   = (ADDR_W + 1)'(VRAM_WORDS);
    localparam logic [ADDR_W:0]   CTRL_WORD  = (ADDR_W + 1)'(CTRL_ADDR);

    logic [STREAK_W-1:0] streak;
    logic [31:0]         ctrl_q;
    logic                cpu_turn;
    logic                vid_grant;
    logic                cpu_grant;
    logic [ADDR_W-1:0]   gnt_addr;
    logic                gnt_in_vram;
    logic                gnt_is_ctrl;
    logic                gnt_cpu_wr;
    rsp_tag_t            tag_d;

    // Video has priority until it has won MAX_VID_STREAK times over a waiting CPU
    assign cpu_turn  = cpu_req_valid && (streak == STREAK_MAX);
    assign vid_grant = axi_aresetn && vid_req_valid && !cpu_turn;
    assign cpu_grant = axi_aresetn && cpu_req_valid && !vid_grant;

    assign vid_req_ready = vid_grant;
    assign cpu_req_ready = cpu_grant;

    assign gnt_addr    = cpu_grant ? cpu_req_addr : vid_req_addr;
    assign gnt_in_vram = ({1'b0, gnt_addr} < VRAM_END);
    assign gnt_is_ctrl = cpu_grant && ({1'b0, cpu_req_addr} == CTRL_WORD);
    assign gnt_cpu_wr  = cpu_grant && cpu_req_we;

    assign bram_en    = (vid_grant || cpu_grant) && gnt_in_vram;
    assign bram_we    = (gnt_cpu_wr && gnt_in_vram) ? cpu_req_strb : 4'b0000;
    assign bram_addr  = gnt_addr;
    assign bram_wdata = cpu_req_wdata;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            streak <= '0;
        end else if (!cpu_req_valid || cpu_grant) begin
            streak <= '0;
        end else if (vid_grant && (streak != STREAK_MAX)) begin
            streak <= streak + 1'b1;
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            ctrl_q <= 32'h0;
        end else if (gnt_is_ctrl && cpu_req_we) begin
            ctrl_q <= byte_merge(ctrl_q, cpu_req_wdata, cpu_req_strb);
        end
    end

    assign ctrl_reg = ctrl_q;

    // Write acks and out-of-range accesses return zero; ctrl reads return the pre-edge value
    always_comb begin
        tag_d.valid         = vid_grant || cpu_grant;
        tag_d.owner         = cpu_grant ? OWN_CPU : OWN_VID;
        tag_d.err           = cpu_grant && !gnt_in_vram && !gnt_is_ctrl;
        tag_d.ctrl_snapshot = ctrl_q;
        if (gnt_cpu_wr) begin
            tag_d.kind = K_ZERO;
        end else if (gnt_in_vram) begin
            tag_d.kind = K_BRAM;
        end else if (gnt_is_ctrl) begin
            tag_d.kind = K_CTRL;
        end else begin
            tag_d.kind = K_ZERO;
        end
    end

    vram_rsp_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rsp_pipe (
        .clk           (axi_aclk),
        .rst_n         (axi_aresetn),
        .tag_in        (tag_d),
        .bram_rdata    (bram_rdata),
        .vid_rsp_valid (vid_rsp_valid),
        .vid_rsp_data  (vid_rsp_data),
        .cpu_rsp_valid (cpu_rsp_valid),
        .cpu_rsp_data  (cpu_rsp_data),
        .cpu_rsp_err   (cpu_rsp_err)
    );

endmodule
